// File: rtl/shift_est_pkg.sv
// Shared types and sizing helpers for the shift estimator and its leading-one detector.
// Holds the FSM encoding, the default SHIFT_MAX and the window-count width helper.
package shift_est_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CALC  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int shift_max(input int shft_width);
    return (1 << shft_width) - 1;
  endfunction

  // Index width for a count/position range of n values, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SHFT_WIDTH_DEF = 4;
  localparam int SHIFT_MAX      = shift_max(SHFT_WIDTH_DEF);
  localparam int WIN_LEN_DEF    = 16;
  localparam int CNT_W          = cnt_width(WIN_LEN_DEF);

endpackage

// File: rtl/shift_estimator_lead_one_det.sv
// Combinational priority encoder: position of the highest set bit of vec, plus a zero flag.
// No state; pos is 0 when vec is all zeros.
module lead_one_det
  import shift_est_pkg::*;
#(
  parameter int W     = 19,
  parameter int POS_W = cnt_width(W)
) (
  input  logic [W-1:0]     vec,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  always_comb begin
    pos  = '0;
    zero = ~|vec;
    // Ascending scan so the highest set bit is the last to write pos.
    for (int i = 0; i < W; i++) begin
      if (vec[i]) pos = POS_W'(i);
    end
  end

endmodule

// File: rtl/shift_estimator.sv
// Smallest right-shift fitting a window of signed samples into OUT_WIDTH bits; SHIFT_EST_STICKY_EN keeps it non-decreasing.
// Latency: shift_valid rises two cycles after the closing sample's accept cycle (one CALC cycle in between).
// Backpressure: in_ready is low outside ACCUM; shift/sat hold stable in HOLD until shift_ready.
module shift_estimator
  import shift_est_pkg::*;
#(
  parameter int IN_WIDTH   = 20,
  parameter int SHFT_WIDTH = 4,
  parameter int OUT_WIDTH  = 8,
  parameter int WIN_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  shift_valid,
  input  logic                  shift_ready,
  output logic [SHFT_WIDTH-1:0] shift,
  output logic                  sat
);

  localparam int MAG_W  = IN_WIDTH - 1;
  localparam int POS_W  = cnt_width(MAG_W);
  localparam int CW     = cnt_width(WIN_LEN);
  localparam int SMAX_I = shift_max(SHFT_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIN_LEN - 1);

  state_e                  state_q, state_d;
  logic [MAG_W-1:0]        max_mag_q, max_mag_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SHFT_WIDTH-1:0]   shift_q, shift_d;
  logic                    sat_q, sat_d;

  logic [MAG_W-1:0]        mag;
  logic                    accept;
  logic [POS_W-1:0]        lod_pos;
  logic                    lod_zero;
  logic [31:0]             b_req, s_req;
  logic                    win_sat;
  logic [SHFT_WIDTH-1:0]   win_shift;

  lead_one_det #(
    .W     (MAG_W),
    .POS_W (POS_W)
  ) u_lod (
    .vec  (max_mag_q),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  assign in_ready    = (state_q == ACCUM);
  assign shift_valid = (state_q == HOLD);
  assign shift       = shift_q;
  assign sat         = sat_q;
  assign accept      = in_valid && in_ready;

  // One's complement keeps the most negative input representable in MAG_W bits.
  assign mag = in_data[IN_WIDTH-1] ? ~in_data[MAG_W-1:0] : in_data[MAG_W-1:0];

  always_comb begin
    b_req     = lod_zero ? 32'd0 : 32'(lod_pos) + 32'd1;
    s_req     = (b_req > 32'(OUT_WIDTH - 1)) ? b_req - 32'(OUT_WIDTH - 1) : 32'd0;
    win_sat   = (s_req > 32'(SMAX_I));
    win_shift = SHFT_WIDTH'(win_sat ? 32'(SMAX_I) : s_req);
  end

  always_comb begin
    state_d   = state_q;
    max_mag_d = max_mag_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sat_d     = sat_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          max_mag_d = (mag > max_mag_q) ? mag : max_mag_q;
          cnt_d     = cnt_q + CW'(1);
          if (in_last || (cnt_q == CNT_LAST)) state_d = CALC;
        end
      end
      CALC: begin
`ifdef SHIFT_EST_STICKY_EN
        // shift_q/sat_q only change here and reset to 0, so they double as the history.
        shift_d = (win_shift > shift_q) ? win_shift : shift_q;
        sat_d   = win_sat | sat_q;
`else
        shift_d = win_shift;
        sat_d   = win_sat;
`endif
        state_d = HOLD;
      end
      HOLD: begin
        if (shift_ready) begin
          state_d   = ACCUM;
          max_mag_d = '0;
          cnt_d     = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      max_mag_q <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_mag_q <= max_mag_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_shift_estimator.sv
// Scoreboard bench for shift_estimator: directed windows push expected {shift,sat}; a monitor pops on each handshake.
// A second instance with SHFT_WIDTH=3 covers the saturating clamp.
module tb_shift_estimator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, shift_ready = 1'b1;
  logic [19:0] in_data = '0;
  logic        in_ready, shift_valid, sat;
  logic [3:0]  shift;

  logic        in_valid_b = 1'b0, in_last_b = 1'b0, shift_ready_b = 1'b1;
  logic [19:0] in_data_b = '0;
  logic        in_ready_b, shift_valid_b, sat_b;
  logic [2:0]  shift_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] shift;
    logic       sat;
  } exp_t;
  exp_t sb_q[$];

`ifdef SHIFT_EST_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  shift_estimator #(.IN_WIDTH(20), .SHFT_WIDTH(4), .OUT_WIDTH(8), .WIN_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .shift_valid(shift_valid), .shift_ready(shift_ready),
    .shift(shift), .sat(sat)
  );

  shift_estimator #(.IN_WIDTH(20), .SHFT_WIDTH(3), .OUT_WIDTH(8), .WIN_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .in_last(in_last_b), .shift_valid(shift_valid_b), .shift_ready(shift_ready_b),
    .shift(shift_b), .sat(sat_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int s, input bit st);
    exp_t e;
    e.shift = s[3:0];
    e.sat   = st;
    sb_q.push_back(e);
  endfunction

  // Monitor: a handshake at the coming edge consumes one expected window.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && shift_valid && shift_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got shift=%0d sat=%0d, expected no pending window", shift, sat);
      end else begin
        e = sb_q.pop_front();
        check("win_shift", int'(shift), int'(e.shift));
        check("win_sat", int'(sat), int'(e.sat));
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; returns just after the accepting edge.
  task automatic send(input logic [19:0] d, input bit last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance of %0h", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending windows, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_shift_valid"}, int'(shift_valid), 0);
    check({tag, "_shift"}, int'(shift), 0);
    check({tag, "_sat"}, int'(sat), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // {1,2,3,100}: max 100 needs 7 bits -> no shift; check CALC bubble then HOLD.
    push(0, 1'b0);
    send(20'd1, 1'b0); send(20'd2, 1'b0); send(20'd3, 1'b0); send(20'd100, 1'b0);
    check("lat_calc_cycle", int'(shift_valid), 0);
    @(posedge clk);
    #1;
    check("lat_hold_cycle", int'(shift_valid), 1);
    drain();

    // {0,0,0,1000}: 10 bits -> shift 3.
    do_reset();
    push(3, 1'b0);
    send(20'd0, 1'b0); send(20'd0, 1'b0); send(20'd0, 1'b0); send(20'd1000, 1'b0);
    drain();

    // Early close; -128 -> mag 127 fits, -129 -> mag 128 needs one shift.
    do_reset();
    push(0, 1'b0);
    send(20'hFFF80, 1'b0); send(20'd5, 1'b1);
    push(1, 1'b0);
    send(20'hFFF7F, 1'b1);
    drain();

    // Consumer stall for 5 cycles with an upstream sample held.
    do_reset();
    shift_ready = 1'b0;
    push(3, 1'b0);
    send(20'd1000, 1'b0); send(20'd0, 1'b0); send(20'd0, 1'b0); send(20'd0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 20'd1000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", int'(shift_valid), 1);
      check("stall_shift", int'(shift), 3);
      check("stall_sat", int'(sat), 0);
      check("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    shift_ready = 1'b1;
    push(3, 1'b0);
    @(negedge clk);
    check("held_handshake_cycle_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("held_accept_cycle_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    drain();

    // Reset mid-window discards the partial (large) window.
    send(20'h7FFFF, 1'b0); send(20'd5, 1'b0);
    do_reset();
    check_idle("rst_mid");
    push(3, 1'b0);
    send(20'd1000, 1'b0); send(20'd0, 1'b0); send(20'd0, 1'b0); send(20'd0, 1'b0);
    drain();

    // Small window after a shift-3 window: history decides.
    push(STICKY ? 3 : 0, 1'b0);
    send(20'd1, 1'b0); send(20'd1, 1'b0); send(20'd1, 1'b0); send(20'd1, 1'b0);
    drain();

    // in_last on the WIN_LEN-th sample closes exactly once; 300 -> shift 2.
    push(STICKY ? 3 : 2, 1'b0);
    send(20'd1, 1'b0); send(20'd1, 1'b0); send(20'd1, 1'b0); send(20'd300, 1'b1);
    drain();

    // Most negative input -> shift 12 unclamped; then an all-zero window.
    do_reset();
    push(12, 1'b0);
    send(20'h80000, 1'b1);
    push(STICKY ? 12 : 0, 1'b0);
    send(20'd0, 1'b0); send(20'd0, 1'b0); send(20'd0, 1'b0); send(20'd0, 1'b0);
    drain();

    // SHFT_WIDTH=3: raw shift 12 clamps to 7 with sat.
    in_valid_b = 1'b1; in_data_b = 20'h7FFFF; in_last_b = 1'b1;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0; in_last_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (shift_valid_b) begin
        seen = 1'b1;
        check("clamp_shift", int'(shift_b), 7);
        check("clamp_sat", int'(sat_b), 1);
      end
    end
    check("clamp_valid_seen", int'(seen), 1);

    repeat (4) @(posedge clk);
    check("final_pending", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
